// File: rtl/add_arbiter.sv
// Round-robin share of one 32-bit ripple-carry adder; result in ADD_CYCLES+1 cycles, one transaction in flight.
// Response held in HOLD until rsp_ready; no grants outside IDLE. `ADD_ARB_OVF_EN adds the rsp_ovf signed-overflow flag.
module add_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADD_CYCLES = 2,
  parameter int ID_W       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  input  logic [NUM_REQ-1:0]     req_cin,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_sum,
  output logic                   rsp_cout,
`ifdef ADD_ARB_OVF_EN
  output logic                   rsp_ovf,
`endif
  output logic                   busy
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        op_a;
  logic [31:0]        op_b;
  logic               op_cin;
  logic [ID_W-1:0]    op_id;

  logic               gnt_vld;
  logic [ID_W-1:0]    gnt_id;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  logic               sel_cin;

  logic [31:0]        sum_raw;
  logic               cout_raw;
  logic               ovf_raw;

  // Scan offsets from farthest to nearest so the requester closest to rr_ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    gnt_oh  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == (int'(rr_ptr) + k) % NUM_REQ && req_valid[i]) begin
          gnt_vld   = 1'b1;
          gnt_id    = ID_W'(i);
          gnt_oh    = '0;
          gnt_oh[i] = 1'b1;
          sel_a     = req_a[32*i +: 32];
          sel_b     = req_b[32*i +: 32];
          sel_cin   = req_cin[i];
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && gnt_vld) begin
      req_ready = gnt_oh;
    end
  end

  // Shared ripple-carry datapath, fed only from the capture registers.
  always_comb begin
    logic c;
    sum_raw = '0;
    c       = op_cin;
    for (int j = 0; j < 32; j++) begin
      sum_raw[j] = op_a[j] ^ op_b[j] ^ c;
      c          = (op_a[j] & op_b[j]) | (c & (op_a[j] ^ op_b[j]));
    end
    cout_raw = c;
  end

  assign ovf_raw = (op_a[31] == op_b[31]) && (sum_raw[31] != op_a[31]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      busy      <= 1'b0;
`ifdef ADD_ARB_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_cin <= sel_cin;
            op_id  <= gnt_id;
            cnt    <= CNT_W'(ADD_CYCLES - 1);
            busy   <= 1'b1;
            state  <= ADD;
          end
        end
        ADD: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_sum   <= sum_raw;
            rsp_cout  <= cout_raw;
            rsp_id    <= op_id;
            rsp_valid <= 1'b1;
`ifdef ADD_ARB_OVF_EN
            rsp_ovf   <= ovf_raw;
`endif
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            if (int'(rsp_id) == NUM_REQ - 1) begin
              rr_ptr <= '0;
            end else begin
              rr_ptr <= rsp_id + 1'b1;
            end
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef ADD_ARB_OVF_EN
  logic unused_ovf;
  assign unused_ovf = ovf_raw;
`endif

endmodule
